// File: rtl/flight_ctrl_pkg.sv
// Shared flight-control definitions: collector FSM states and the default
// MPU-style frame layout.
package flight_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_DONE = 2'd2
   } fsm_state_t;

   localparam int unsigned FRAME_BYTES_DEF = 14;
   // accel XYZ at 0/2/4, temperature at 6 (unmapped), gyro XYZ at 8/10/12
   localparam logic [47:0] CHAN_OFS_DEF = {8'd12, 8'd10, 8'd8, 8'd4, 8'd2, 8'd0};

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, followed by a history
// flop that turns its rising edge into a single-cycle pulse.
module sync_edge_det #(
   parameter int unsigned SYNC_STAGES = 3
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic ASYNC_IN,
   output logic RISE
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ASYNC_IN};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign RISE = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/sensor_frame_collector.sv
// IMU frame collector: on a data-ready interrupt requests an I2C burst,
// scatters the bytes into per-channel registers and reports frame status.
module sensor_frame_collector
   import flight_ctrl_pkg::*;
#(
   parameter int unsigned           NUM_CHAN    = 6,
   parameter int unsigned           CHAN_BYTES  = 2,
   parameter int unsigned           FRAME_BYTES = FRAME_BYTES_DEF,
   parameter logic [NUM_CHAN*8-1:0] CHAN_OFS    = CHAN_OFS_DEF,
   parameter int unsigned           SYNC_STAGES = 3,
   parameter int unsigned           TIMEOUT_CYC = 65535
) (
   input  logic                             CLK,
   input  logic                             RST_N,
   input  logic                             ICU_INT,
   input  logic                             CFG_LE,
   input  logic [7:0]                       I2C_READ_DATA,
   input  logic                             I2C_READ_VALID,
   input  logic                             I2C_BUSY,
   output logic                             I2C_READ_EN,
   output logic [NUM_CHAN*CHAN_BYTES*8-1:0] CHAN_DATA,
   output logic [NUM_CHAN-1:0]              CHAN_VALID,
   output logic                             FRAME_VALID,
   output logic                             FRAME_ERR,
   output logic [7:0]                       OVERRUN_CNT
);

   localparam int unsigned CHAN_W    = 8 * CHAN_BYTES;
   localparam logic [7:0]  FRAME_LEN = 8'(FRAME_BYTES);
   localparam logic [15:0] WD_LAST   = 16'(TIMEOUT_CYC - 1);

   fsm_state_t  state_q, state_d;
   logic        int_evt, byte_evt, busy_fall, timeout, store_evt;
   logic        valid_dl, busy_dl, err_flag;
   logic [7:0]  byte_cnt;
   logic [15:0] wd_cnt;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .ASYNC_IN (ICU_INT),
      .RISE     (int_evt)
   );

   assign byte_evt  = I2C_READ_VALID & ~valid_dl;
   assign busy_fall = busy_dl & ~I2C_BUSY;
   assign timeout   = (state_q == ST_READ) && (wd_cnt == WD_LAST);
   assign store_evt = byte_evt && (state_q == ST_READ) && (byte_cnt < FRAME_LEN);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (int_evt) state_d = ST_READ;
         ST_READ: if (timeout || busy_fall) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      I2C_READ_EN = 1'b0;
      FRAME_VALID = 1'b0;
      FRAME_ERR   = 1'b0;
      case (state_q)
         ST_READ: I2C_READ_EN = 1'b1;
         ST_DONE: begin
            if ((byte_cnt == FRAME_LEN) && !err_flag) FRAME_VALID = 1'b1;
            else                                      FRAME_ERR   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid_dl    <= 1'b0;
         busy_dl     <= 1'b0;
         byte_cnt    <= '0;
         wd_cnt      <= '0;
         err_flag    <= 1'b0;
         OVERRUN_CNT <= '0;
      end else begin
         valid_dl <= I2C_READ_VALID;
         busy_dl  <= I2C_BUSY;
         wd_cnt   <= (state_q == ST_READ) ? wd_cnt + 16'd1 : '0;
         if ((state_q == ST_IDLE) && int_evt)
            byte_cnt <= '0;
         else if ((state_q == ST_READ) && byte_evt && (byte_cnt != 8'hFF))
            byte_cnt <= byte_cnt + 8'd1;
         if ((state_q == ST_IDLE) && int_evt) err_flag <= 1'b0;
         else if (timeout)                    err_flag <= 1'b1;
         if (int_evt && (state_q != ST_IDLE) && (OVERRUN_CNT != 8'hFF))
            OVERRUN_CNT <= OVERRUN_CNT + 8'd1;
      end
   end

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
      localparam logic [8:0] OFS = {1'b0, CHAN_OFS[8*c +: 8]};
      logic [8:0]        pos;
      logic              hit;
      logic [CHAN_W-1:0] chan_q;
      logic              cv_q;

      // pos is only meaningful when the byte index is at or past this channel's offset
      assign pos = {1'b0, byte_cnt} - OFS;
      assign hit = store_evt && ({1'b0, byte_cnt} >= OFS) && (pos < 9'(CHAN_BYTES));

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            chan_q <= '0;
            cv_q   <= 1'b0;
         end else begin
            cv_q <= hit && (pos == 9'(CHAN_BYTES - 1));
            for (int unsigned b = 0; b < CHAN_BYTES; b++) begin
               if (hit && (pos == 9'(b))) begin
                  if (CFG_LE) chan_q[8*b +: 8]          <= I2C_READ_DATA;
                  else        chan_q[CHAN_W-1-8*b -: 8] <= I2C_READ_DATA;
               end
            end
         end
      end

      assign CHAN_DATA[c*CHAN_W +: CHAN_W] = chan_q;
      assign CHAN_VALID[c]                 = cv_q;
   end

endmodule
